// File: rtl/lsf_spy_readout.sv
// Read-side controller for the MDT-hit spy buffer.
// A start command freezes the spy buffer, reads a programmed address window one word at a time,
// and streams each word downstream. The freeze is released when the window finishes.
//
// Downstream handshake (valid/ready): o_valid rises with o_data/o_last already stable.
// o_data, o_valid and o_last do not change until the cycle in which i_ready is high,
// and that cycle transfers the word. o_valid never waits on i_ready.
// i_ready may toggle freely.
module lsf_spy_readout #(
    parameter int DATA_WIDTH    = 40,
    parameter int ADDR_WIDTH    = 10,
    parameter int RD_LATENCY    = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  sb_freeze,
    output logic                  sb_re,
    output logic [ADDR_WIDTH-1:0] sb_raddr,
    input  logic [DATA_WIDTH-1:0] sb_rdata,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Final counter value of the settle and read-latency phases. The counter restarts at 0 on entry.
    localparam int SETTLE_LAST_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int WAIT_LAST_I   = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_LAST_I);
    localparam logic [3:0] WAIT_LAST   = 4'(WAIT_LAST_I);
    localparam logic [ADDR_WIDTH:0] ONE_WORD = (ADDR_WIDTH+1)'(1);

    state_t                state, state_next;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;

    logic take_start;
    logic take_abort;
    logic load_data;
    logic handshake;

    assign sb_raddr  = addr;
    assign fsm_state = state;

    // State register, plus the phase counter shared by SETTLE and WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if ((state == S_SETTLE || state == S_WAIT) && state_next == state)
                cnt <= cnt + 4'd1;
            else
                cnt <= '0;
        end
    end

    // Next-state logic and the combinational strobes that steer the datapath.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        sb_re      = 1'b0;
        take_start = 1'b0;
        take_abort = 1'b0;
        load_data  = 1'b0;
        handshake  = 1'b0;
        case (state)
            S_IDLE: begin
                // Abort has priority, so a start in the same cycle is dropped.
                if (start && !abort) begin
                    take_start = 1'b1;
                    if (length == '0)
                        state_next = S_DONE;
                    else if (SETTLE_CYCLES == 0)
                        state_next = S_ISSUE;
                    else
                        state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt == SETTLE_LAST)
                    state_next = S_ISSUE;
            end
            S_ISSUE: begin
                busy       = 1'b1;
                sb_re      = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt == WAIT_LAST) begin
                    load_data  = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                busy = 1'b1;
                if (i_ready) begin
                    handshake  = 1'b1;
                    state_next = (remaining == ONE_WORD) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // DONE is excluded: the window has already completed there and busy is low.
        // A word accepted in the abort cycle is still counted, because handshake stays set.
        if (abort && state != S_IDLE && state != S_DONE) begin
            take_abort = 1'b1;
            load_data  = 1'b0;
            state_next = S_IDLE;
        end
    end

    // Window registers, output word register, freeze and status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            remaining  <= '0;
            word_count <= '0;
            sb_freeze  <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            aborted <= take_abort;
            if (take_start) begin
                addr       <= start_addr;
                remaining  <= length;
                word_count <= '0;
                sb_freeze  <= (length != '0);
            end
            if (load_data) begin
                o_data  <= sb_rdata;
                o_valid <= 1'b1;
                o_last  <= (remaining == ONE_WORD);
            end
            if (handshake) begin
                o_valid    <= 1'b0;
                o_last     <= 1'b0;
                addr       <= addr + ADDR_WIDTH'(1);
                remaining  <= remaining - ONE_WORD;
                word_count <= word_count + ONE_WORD;
            end
            if (state == S_DONE)
                sb_freeze <= 1'b0;
            if (take_abort) begin
                sb_freeze <= 1'b0;
                o_valid   <= 1'b0;
                o_last    <= 1'b0;
            end
        end
    end

endmodule
